// File: rtl/ternary_weight_unpacker_pkg.sv
// Shared ternary weight types, 2-bit code constants and the code-to-weight map.
// Also used by the future weight packer.
package ternary_weight_unpacker_pkg;

    typedef enum logic [1:0] {
        W_ZERO = 2'b00,
        W_POS  = 2'b01,
        W_NEG  = 2'b11
    } weight_t;

    localparam logic [1:0] TCODE_ZERO = 2'b00;
    localparam logic [1:0] TCODE_POS  = 2'b01;
    localparam logic [1:0] TCODE_NEG  = 2'b11;
    localparam logic [1:0] TCODE_RSVD = 2'b10;

    // Each code maps to a named member; the reserved code falls through to zero.
    function automatic weight_t tcode_to_weight(input logic [1:0] code);
        case (code)
            TCODE_POS: return W_POS;
            TCODE_NEG: return W_NEG;
            default:   return W_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/ternary_code_dec.sv
// Combinational decode of one packed input word into CPW ternary weights.
// The reserved-code flag exists only when TERNARY_ERR_CHECK_EN is defined.
module ternary_code_dec
    import ternary_weight_unpacker_pkg::*;
#(
    parameter int CPW = 4
) (
    input  logic [2*CPW-1:0] codes,
    output weight_t [CPW-1:0] weights
`ifdef TERNARY_ERR_CHECK_EN
    ,
    output logic             rsvd
`endif
);

    always_comb begin
        for (int k = 0; k < CPW; k++) begin
            weights[k] = tcode_to_weight(codes[2*k +: 2]);
        end
    end

`ifdef TERNARY_ERR_CHECK_EN
    always_comb begin
        // NOTE: default assignment first so no path leaves rsvd unassigned (no latch).
        rsvd = 1'b0;
        for (int k = 0; k < CPW; k++) begin
            if (codes[2*k +: 2] == TCODE_RSVD) rsvd = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/ternary_weight_unpacker.sv
// Gathers packed 2-bit ternary codes into LEN-wide weight vectors behind a
// registered valid/ready output. Optional sticky reserved-code flag: TERNARY_ERR_CHECK_EN.
module ternary_weight_unpacker
    import ternary_weight_unpacker_pkg::*;
#(
    parameter int LEN  = 16,
    parameter int IN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output weight_t [LEN-1:0] o_weight,
    output logic             o_last,
    output logic             o_err
);

    localparam int CPW = IN_W / 2;
    localparam int WPV = 2 * LEN / IN_W;
    localparam int WCW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam weight_t [LEN-1:0] ZERO_VEC = '{default: W_ZERO};

    logic [WCW-1:0]     wcnt;
    weight_t [LEN-1:0]  asm_q;
    weight_t [LEN-1:0]  asm_next;
    weight_t [CPW-1:0]  dec_w;
    logic               last_word;
    logic               accept;
    logic               complete;

`ifdef TERNARY_ERR_CHECK_EN
    logic dec_rsvd;

    ternary_code_dec #(.CPW(CPW)) u_dec (
        .codes   (i_data),
        .weights (dec_w),
        .rsvd    (dec_rsvd)
    );
`else
    ternary_code_dec #(.CPW(CPW)) u_dec (
        .codes   (i_data),
        .weights (dec_w)
    );
`endif

    // Only a completing word needs the output register; earlier words never stall.
    assign last_word = (wcnt == WCW'(WPV - 1)) || i_last;
    assign o_ready   = !(last_word && o_valid && !i_ready);
    assign accept    = i_valid && o_ready;
    assign complete  = accept && last_word;

    // Unwritten slots are already zero, so merging gives zero padding for free.
    always_comb begin
        asm_next = asm_q;
        for (int k = 0; k < WPV; k++) begin
            if (wcnt == WCW'(k)) asm_next[k*CPW +: CPW] = dec_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the assembly buffer is reset as well; its zero state is what pads a short tile.
            wcnt     <= '0;
            asm_q    <= ZERO_VEC;
            o_weight <= ZERO_VEC;
            o_valid  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            if (accept) begin
                if (complete) begin
                    o_weight <= asm_next;
                    o_last   <= i_last;
                    asm_q    <= ZERO_VEC;
                    wcnt     <= '0;
                end else begin
                    asm_q    <= asm_next;
                    wcnt     <= wcnt + 1'b1;
                end
            end

            if (complete) begin
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef TERNARY_ERR_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (accept && dec_rsvd) begin
            o_err <= 1'b1;
        end
    end
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_ternary_weight_unpacker.sv
// Scoreboard bench for ternary_weight_unpacker: directed scenarios plus random
// traffic against a code-list reference model; honours TERNARY_ERR_CHECK_EN.
module tb_ternary_weight_unpacker;
    import ternary_weight_unpacker_pkg::*;

    localparam int LEN  = 16;
    localparam int IN_W = 8;
`ifdef TERNARY_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              i_valid;
    logic              o_ready;
    logic [IN_W-1:0]   i_data;
    logic              i_last;
    logic              o_valid;
    logic              i_ready;
    weight_t [LEN-1:0] o_weight;
    logic              o_last;
    logic              o_err;

    ternary_weight_unpacker #(.LEN(LEN), .IN_W(IN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .i_last   (i_last),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_weight (o_weight),
        .o_last   (o_last),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2*LEN-1:0] w;
        logic             last;
    } exp_t;

    int      errors = 0;
    int      checks = 0;
    exp_t    exp_q[$];
    weight_t model_codes[$];
    weight_t lut[4] = '{W_ZERO, W_POS, W_ZERO, W_NEG};
    logic    err_next = 1'b0;
    logic    err_cur  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a flat list of decoded codes; a vector closes at LEN codes or on a tile end.
    task automatic model_word(input logic [IN_W-1:0] d, input logic l);
        exp_t e;
        for (int j = 0; j < IN_W/2; j++) begin
            model_codes.push_back(lut[d[2*j +: 2]]);
            if (ERR_EN && d[2*j +: 2] == 2'b10) err_next = 1'b1;
        end
        if (model_codes.size() == LEN || l) begin
            e.w = '0;
            for (int s = 0; s < model_codes.size(); s++) e.w[2*s +: 2] = model_codes[s];
            e.last = l;
            exp_q.push_back(e);
            model_codes.delete();
        end
    endtask

    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic l,
                         input logic r, output logic acc);
        @(negedge clk);
        i_valid = v;
        i_data  = d;
        i_last  = l;
        i_ready = r;
        #1;
        acc = v && o_ready;
        if (acc) model_word(d, l);
    endtask

    task automatic send_word(input logic [IN_W-1:0] d, input logic l, input logic r);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            drive(1'b1, d, l, r, acc);
            n++;
        end
        check("accept_timeout", acc, 1'b1);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst     = 1'b1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        model_codes.delete();
        exp_q.delete();
        err_next = 1'b0;
        err_cur  = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
            check("valid_in_rst", o_valid, 1'b0);
        end
        rst = 1'b0;
    endtask

    // Monitor: compares the presented vector with the queue head every cycle it is valid.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_vector: got %h, expected none (t=%0t)", o_weight, $time);
                end else begin
                    check("weight", o_weight, exp_q[0].w);
                    check("last", o_last, exp_q[0].last);
                    if (i_ready) void'(exp_q.pop_front());
                end
            end
            check("err", o_err, err_cur);
        end
        err_cur = err_next;
    end

    initial begin
        logic acc;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_last  = 1'b0;
        i_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid", o_valid, 1'b0);
        check("rst_last", o_last, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_weight", o_weight, 0);
        check("rst_ready", o_ready, 1'b1);

        // Single vector with latency check.
        send_word(8'h1D, 1'b0, 1'b1);
        send_word(8'h00, 1'b0, 1'b1);
        send_word(8'hFF, 1'b0, 1'b1);
        send_word(8'h55, 1'b0, 1'b1);
        check("valid_before", o_valid, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("valid_latency", o_valid, 1'b1);
        check("vec1_weight", o_weight, 32'h55FF_001D);
        check("vec1_last", o_last, 1'b0);

        // Back-to-back words never see back-pressure.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b1, acc);
            check("b2b_ready", acc, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);

        // Back-pressure stalls only the completing word.
        for (int i = 0; i < 4; i++) send_word(8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
            check("bp_early_accept", acc, 1'b1);
        end
        repeat (3) begin
            drive(1'b1, 8'hC3, 1'b0, 1'b0, acc);
            check("bp_stall", acc, 1'b0);
        end
        drive(1'b1, 8'hC3, 1'b0, 1'b1, acc);
        check("bp_release", acc, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);

        // Short tile: i_last on word 1.
        send_word(8'h55, 1'b0, 1'b1);
        send_word(8'hFF, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("short_weight", o_weight, 32'h0000_FF55);
        check("short_last", o_last, 1'b1);
        send_word(8'h1D, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("next_slot0", o_weight, 32'h0000_001D);

        // Reserved code.
        send_word(8'h02, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("rsvd_weight", o_weight, 0);
        check("rsvd_err", o_err, ERR_EN);
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("rsvd_err_hold", o_err, ERR_EN);

        // Reset mid-vector discards the partial vector.
        send_word(8'hFF, 1'b0, 1'b1);
        send_word(8'hFF, 1'b0, 1'b1);
        apply_reset(2);
        check("post_rst_err", o_err, 1'b0);
        send_word(8'h01, 1'b0, 1'b1);
        send_word(8'h04, 1'b0, 1'b1);
        send_word(8'h10, 1'b0, 1'b1);
        send_word(8'h40, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("post_rst_weight", o_weight, 32'h4010_0401);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 6), acc);
        end
        repeat (5) drive(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ternary_weight_unpacker.md
# ternary_weight_unpacker

Streaming decoder that turns packed 2-bit ternary weight codes, read from weight memory over a narrow byte-oriented stream, into full `LEN`-wide `weight_t` vectors for the ternary dot-product core. It gathers several input words per vector and drives its output from a registered stage with a valid/ready handshake. It sits between the weight-fetch DMA and the dot-product core's weight input. A tile's final partial vector is zero-padded.

## Interface
- `LEN`, 16: weights per output vector; must match the dot-product core's parallelism.
- `IN_W`, 8: input word width in bits; must be even, and `2*LEN % IN_W == 0`.
- Derived: `CPW = IN_W/2` codes per word; `WPV = 2*LEN/IN_W` words per vector (4 at defaults).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: input word valid.
- `o_ready` out 1: unpacker accepts a word this cycle.
- `i_data` in `IN_W`: packed codes. Code j sits at bits `[2j+1:2j]`, LSB first.
- `i_last` in 1: this word is the final word of a weight tile.
- `o_valid` out 1: `o_weight` holds a complete vector.
- `i_ready` in 1: consumer takes the vector.
- `o_weight` out `weight_t [LEN-1:0]`: decoded vector.
- `o_last` out 1: vector is the final one of a tile.
- `o_err` out 1: sticky flag for a reserved code (see Configuration).

## Operation
- Code map:
  - 2'b00 → `W_ZERO`
  - 2'b01 → `W_POS`
  - 2'b11 → `W_NEG`
  - 2'b10 is reserved → `W_ZERO`
- Codes are mapped explicitly to enum members, never cast.
- Word counter `wcnt` runs 0..WPV-1. An accepted word (`i_valid && o_ready`) decodes into assembly slots `[wcnt*CPW +: CPW]`.
- Completion: a vector is complete on an accepted word with `wcnt==WPV-1` or with `i_last=1`.
  - On completion the vector moves into the output register and `wcnt` returns to 0.
  - Slots not yet written in the current vector are loaded as `W_ZERO`.
  - `o_last` is set equal to the completing word's `i_last`.
- Non-completing accepted word: `wcnt` increments.
- `o_ready` is 1 unless the next accepted word would complete a vector while the output register is full (`o_valid && !i_ready`). This is combinational from `wcnt`, `i_last`, `o_valid` and `i_ready`.
- Output register states:
  - EMPTY (`o_valid=0`): goes to FULL on completion.
  - FULL: goes to EMPTY on `i_ready` with no completion.
  - FULL with `i_ready` and completion in the same cycle: stays FULL and loads the new vector.
- `o_weight`/`o_last` stay stable while `o_valid && !i_ready`.
- Assembly slots are cleared to `W_ZERO` when a vector completes.

## Timing
- Reset values: `o_valid=0`, `o_last=0`, `o_err=0`, `o_weight` all `W_ZERO`, `wcnt=0`, assembly all `W_ZERO`. `o_ready=1` in the first cycle after reset.
- `rst` mid-vector discards the partial vector and any pending output vector.
- Latency: `o_valid` rises the cycle after the completing word is accepted.
- Throughput: one word per cycle sustained with `i_ready` held high, i.e. one vector per `WPV` cycles.
- Back-pressure stalls only the completing word. Words 0..WPV-2 of the next vector are accepted while the output waits.
- `i_last` on word 0 produces a vector with `CPW` live codes and the rest `W_ZERO`.

## Configuration
- `TERNARY_ERR_CHECK_EN` defined:
  - An accepted word containing 2'b10 in any code sets `o_err` on the next cycle.
  - `o_err` holds until `rst`.
  - The code still decodes to `W_ZERO`.
- `TERNARY_ERR_CHECK_EN` undefined:
  - `o_err` is tied to 0.
  - No detection logic is instantiated.
  - Decode is unchanged.

## Structure
- `package_def`:
  - `weight_t`
  - code constants `TCODE_ZERO`, `TCODE_POS`, `TCODE_NEG`, `TCODE_RSVD`
  - function `tcode_to_weight(logic [1:0])`, shared with the future weight packer
- One sub-module, `ternary_code_dec`: combinational, `CPW` codes in, `CPW` weights plus a per-word reserved flag out.
- Counter, assembly buffer and output register live in the top module.

## Test plan
All scenarios use defaults (`LEN=16`, `IN_W=8`).
- Words 0x1D, 0x00, 0xFF, 0x55 with `i_ready=1` → one vector. Slots 0..3 = +1,-1,+1,0; 4..7 = 0; 8..11 = -1; 12..15 = +1. `o_valid` is high 1 cycle after the 4th word, `o_last=0`.
- 8 back-to-back words with `i_valid=1`, `i_ready=1` → `o_ready` stays 1 throughout; two vectors, one cycle apart from their completing words.
- `i_ready=0` after vector 1 → next 3 words accepted. The 4th word sees `o_ready=0` until `i_ready=1`, then vector 1 leaves and vector 2 loads the same cycle.
- `i_last=1` on word 1 (words 0x55, 0xFF) → slots 0..3 = +1, slots 4..7 = -1, 8..15 = 0; `o_last=1`; next word lands in slots 0..3.
- Word 0x02 with `TERNARY_ERR_CHECK_EN` defined → slot 0 = `W_ZERO`, `o_err=1` next cycle and held until `rst`. Without the macro → `o_err` stays 0.
- `rst` after 2 of 4 words → next vector is built from the next 4 words only; `o_valid=0` throughout reset.
